branch_history_manager: RTL
===========================

Name: branch_history_manager

Overview:
- Speculative global-history and in-flight-branch bookkeeping for the gshare predictor, between decode (prediction request) and EX (branch feedback).
- Updates a speculative GHR at prediction time, not at resolution.
- Records each predicted branch's PHT index and prediction in an in-order checkpoint FIFO.
- On resolution, supplies the PHT update index and detects misprediction; on misprediction or pipeline flush, repairs the speculative GHR from the committed GHR.

Parameters:
- GHR_BITS, 8, global history length (>=2).
- IDX_BITS, 8, PHT index width; IDX_BITS <= GHR_BITS.
- DEPTH, 4, max in-flight predicted branches; power of two, >=2.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active low.
- i_req_valid  in  1  decode requests a prediction for a conditional branch.
- i_req_pc  in  ADDR_WIDTH  PC of the requesting branch.
- i_req_prediction  in  1  predictor outcome for this request (1=TAKEN, 0=NOT_TAKEN).
- o_req_ready  out  1  request can be accepted this cycle.
- o_req_index  out  IDX_BITS  PHT index for the current request.
- i_fb_valid  in  1  EX resolves the oldest in-flight branch.
- i_fb_outcome  in  1  actual outcome (1=TAKEN).
- o_fb_index  out  IDX_BITS  PHT index recorded for the head entry.
- o_fb_mispredict  out  1  head prediction != i_fb_outcome (qualified by i_fb_valid).
- o_fb_error  out  1  feedback arrived while FIFO empty.
- i_flush  in  1  non-branch pipeline flush; discard all in-flight branches.
- o_spec_ghr  out  GHR_BITS  speculative GHR.
- o_arch_ghr  out  GHR_BITS  committed GHR.
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at posedge):
  - spec_ghr=0, arch_ghr=0, head=tail=0, count=0.
  - o_req_ready=1 after reset; entry storage is not cleared.
- Index:
  - o_req_index = spec_ghr[IDX_BITS-1:0] ^ i_req_pc[IDX_BITS+1:2].
  - Combinational, zero latency.
- o_req_ready = (count < DEPTH). Registered-state only; no pass-through when full, even if a pop occurs in the same cycle.
- Push:
  - Condition: i_req_valid & o_req_ready & ~i_flush & ~(i_fb_valid & o_fb_mispredict).
  - Action: entry[tail] <= {o_req_index, i_req_prediction}; tail++ (wraps mod DEPTH).
  - spec_ghr <= {spec_ghr[GHR_BITS-2:0], i_req_prediction}.
- Pop:
  - Condition: i_fb_valid & count>0.
  - Action: head++ (mod DEPTH); arch_ghr <= {arch_ghr[GHR_BITS-2:0], i_fb_outcome}.
- o_fb_index = entry[head].index; o_fb_mispredict = i_fb_valid & count>0 & (entry[head].pred != i_fb_outcome). Both are combinational.
- Mispredict (pop with o_fb_mispredict=1):
  - All younger entries are wrong-path: count <= 0, tail <= head+1.
  - spec_ghr <= {arch_ghr[GHR_BITS-2:0], i_fb_outcome}, which equals the new arch_ghr.
  - A same-cycle push is dropped.
- i_flush:
  - count <= 0, tail <= head', where head' is head after any same-cycle pop.
  - spec_ghr <= new arch_ghr, including any same-cycle pop's outcome.
  - Push is dropped; a same-cycle correct or incorrect pop still commits to arch_ghr.
- Precedence: reset > flush > mispredict > push/pop.
- Push and correct pop in the same cycle: both take effect; count unchanged.
- Feedback with count==0:
  - No state change.
  - o_fb_error = i_fb_valid & (count==0), combinational; o_fb_mispredict=0.
- Invariant (verification assertion): when count>0, arch_ghr equals the spec_ghr value at the time the head entry was pushed.
- Counters and GHRs wrap or shift silently; no saturation.

Test Plan:
- Reset, then 3 pushes at pc=0x0040_0010 with predictions 1,0,1 -> o_req_index for the first = 0x04, spec_ghr=0x05, o_count=3, arch_ghr=0.
- Fill to DEPTH=4 -> o_req_ready=0; push attempt while full with a simultaneous correct pop -> push dropped, count=3, ready=1 next cycle.
- Head pred=1, fb outcome=1 with a same-cycle push pred=0 -> no mispredict, count unchanged, arch_ghr shifts in 1, spec_ghr shifts in 0.
- 3 in flight (preds 1,1,1; arch_ghr=0x00), fb outcome=0 -> o_fb_mispredict=1, count=0, arch_ghr=0x00, spec_ghr=0x00; a same-cycle push is dropped.
- Feedback with FIFO empty -> o_fb_error=1, all registers unchanged.
- 2 in flight, i_flush with a same-cycle fb outcome=1 -> count=0, arch_ghr and spec_ghr both = prior arch_ghr<<1|1; next push uses the repaired index.

Source files
------------

// File: rtl/branch_history_manager.sv
// Speculative global-history register and in-flight branch checkpoint FIFO
// for the gshare predictor. The speculative GHR advances when a prediction is
// made. The committed GHR advances when EX resolves the oldest branch. A
// misprediction or flush copies the committed history back into the
// speculative GHR.
module branch_history_manager #(
    parameter int GHR_BITS   = 8,
    parameter int IDX_BITS   = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req_valid,
    input  logic [ADDR_WIDTH-1:0]        i_req_pc,
    input  logic                         i_req_prediction,
    output logic                         o_req_ready,
    output logic [IDX_BITS-1:0]          o_req_index,
    input  logic                         i_fb_valid,
    input  logic                         i_fb_outcome,
    output logic [IDX_BITS-1:0]          o_fb_index,
    output logic                         o_fb_mispredict,
    output logic                         o_fb_error,
    input  logic                         i_flush,
    output logic [GHR_BITS-1:0]          o_spec_ghr,
    output logic [GHR_BITS-1:0]          o_arch_ghr,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Checkpoint storage. It is not reset, because count_q marks which slots are live.
    logic [IDX_BITS-1:0] idx_q [DEPTH];
    logic [DEPTH-1:0]    pred_q;

    logic [GHR_BITS-1:0] spec_ghr_q, spec_ghr_d;
    logic [GHR_BITS-1:0] arch_ghr_q, arch_ghr_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic has_entry;
    logic pop;
    logic push;

    // Only PC bits [IDX_BITS+1:2] hash into the index. The remaining bits are
    // folded together so that the unused input bits stay visible.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:IDX_BITS+2], i_req_pc[1:0]};

    assign has_entry       = (count_q != '0);
    assign o_req_ready     = (count_q < DEPTH_C);
    assign o_req_index     = spec_ghr_q[IDX_BITS-1:0] ^ i_req_pc[IDX_BITS+1:2];
    assign o_fb_index      = idx_q[head_q];
    assign o_fb_mispredict = i_fb_valid & has_entry & (pred_q[head_q] != i_fb_outcome);
    assign o_fb_error      = i_fb_valid & ~has_entry;
    assign pop             = i_fb_valid & has_entry;
    assign push            = i_req_valid & o_req_ready & ~i_flush & ~o_fb_mispredict;

    assign o_spec_ghr = spec_ghr_q;
    assign o_arch_ghr = arch_ghr_q;
    assign o_count    = count_q;

    // Next-state logic. A flush or a mispredict drops every younger entry and
    // copies the new committed history into the speculative GHR.
    always_comb begin
        arch_ghr_d = arch_ghr_q;
        head_d     = head_q;
        spec_ghr_d = spec_ghr_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (pop) begin
            arch_ghr_d = {arch_ghr_q[GHR_BITS-2:0], i_fb_outcome};
            head_d     = head_q + PTR_ONE;
        end
        if (i_flush || o_fb_mispredict) begin
            count_d    = '0;
            tail_d     = head_d;
            spec_ghr_d = arch_ghr_d;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_ONE;
                spec_ghr_d = {spec_ghr_q[GHR_BITS-2:0], i_req_prediction};
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and history registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_ghr_q <= '0;
            arch_ghr_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            arch_ghr_q <= arch_ghr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Write a checkpoint for each accepted prediction.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            idx_q[tail_q]  <= o_req_index;
            pred_q[tail_q] <= i_req_prediction;
        end
    end

endmodule
